dm_wb_cache: RTL and testbench

- Parametrised direct-mapped, write-back, write-allocate data cache for one core.
- Sits between the core load/store port and the shared RAM arbiter.
- Line size, line count, data width and address width are generics.
- A synchronous FSM replaces wait-based sequencing. Dirty victims are written back on eviction, and peer cores can invalidate lines through a snoop input.

---
 rtl/dm_wb_cache.sv | 208 ++++++++++++++++++++
 tb/tb_dm_wb_cache.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_wb_cache.sv
`default_nettype none
// ============================================================================
// Module   : dm_wb_cache
// Purpose  : Direct-mapped, write-back, write-allocate data cache between one
//            core load/store port and the shared RAM arbiter. Misses are
//            sequenced by a synchronous FSM (IDLE -> [WB ->] FILL -> IDLE);
//            dirty victims are written back whole-line before the refill, and
//            peer cores may invalidate lines through the snoop input.
// Ports    : clk, rst_n                 - clock, async active-low reset
//            cpu_read/cpu_write/cpu_addr/cpu_data_w  - core request (held)
//            cpu_wait/cpu_data_r        - combinational stall / read data
//            ram_addr/ram_data_w/ram_read/ram_write - RAM beat request
//            ram_wait/ram_data_r        - RAM stall / read data
//            inv_valid/inv_addr         - single-cycle snoop invalidate
// Revision : 1.0 - initial release
// ============================================================================
module dm_wb_cache #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int INDEX_W  = 8,
  parameter int OFFSET_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_data_w,
  output logic              cpu_wait,
  output logic [DATA_W-1:0] cpu_data_r,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data_w,
  output logic              ram_read,
  output logic              ram_write,
  input  logic              ram_wait,
  input  logic [DATA_W-1:0] ram_data_r,
  input  logic              inv_valid,
  input  logic [ADDR_W-1:0] inv_addr
);

  localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
  localparam int LINES = 2 ** INDEX_W;
  localparam int WORDS = 2 ** (INDEX_W + OFFSET_W);
  localparam logic [OFFSET_W-1:0] CNT_LAST = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WB   = 2'd1,
    ST_FILL = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [OFFSET_W-1:0] cnt_q, cnt_d;
  logic [TAG_W-1:0]    miss_tag_q, miss_tag_d;
  logic [INDEX_W-1:0]  miss_idx_q, miss_idx_d;
  logic                abort_q, abort_d;

  logic [LINES-1:0]    valid_q, dirty_q;
  logic [TAG_W-1:0]    tag_q  [LINES];
  logic [DATA_W-1:0]   data_q [WORDS];

  // Address field split
  logic [TAG_W-1:0]    w_cpu_tag, w_inv_tag;
  logic [INDEX_W-1:0]  w_cpu_idx, w_inv_idx;
  logic [OFFSET_W-1:0] w_cpu_off;
  logic                w_unused_inv_off;

  assign w_cpu_tag        = cpu_addr[ADDR_W-1 -: TAG_W];
  assign w_cpu_idx        = cpu_addr[OFFSET_W +: INDEX_W];
  assign w_cpu_off        = cpu_addr[OFFSET_W-1:0];
  assign w_inv_tag        = inv_addr[ADDR_W-1 -: TAG_W];
  assign w_inv_idx        = inv_addr[OFFSET_W +: INDEX_W];
  assign w_unused_inv_off = ^inv_addr[OFFSET_W-1:0];

  logic w_req, w_raw_hit, w_hit, w_inv_cpu, w_inv_hit, w_inv_miss;
  logic w_victim_dirty, w_cpu_we;

  assign w_req      = cpu_read | cpu_write;
  assign w_inv_cpu  = inv_valid && (w_inv_tag == w_cpu_tag) && (w_inv_idx == w_cpu_idx);
  assign w_raw_hit  = valid_q[w_cpu_idx] && (tag_q[w_cpu_idx] == w_cpu_tag);
  assign w_hit      = w_raw_hit && !w_inv_cpu;
  // Snoop that actually removes a resident line this cycle
  assign w_inv_hit  = inv_valid && valid_q[w_inv_idx] && (tag_q[w_inv_idx] == w_inv_tag);
  assign w_inv_miss = inv_valid && (w_inv_tag == miss_tag_q) && (w_inv_idx == miss_idx_q);
  // A victim dropped by a snoop in the same cycle is discarded, not written back
  assign w_victim_dirty = valid_q[w_cpu_idx] && dirty_q[w_cpu_idx] &&
                          !(w_inv_hit && (w_inv_idx == w_cpu_idx));

  assign cpu_wait   = w_req && !((state_q == ST_IDLE) && w_hit);
  assign w_cpu_we   = cpu_write && (state_q == ST_IDLE) && w_hit;
  assign cpu_data_r = (cpu_read && (state_q == ST_IDLE) && w_hit) ?
                      data_q[{w_cpu_idx, w_cpu_off}] : '0;

  logic w_fill_we, w_fill_ok, w_fill_abort, w_line_clr;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    miss_tag_d   = miss_tag_q;
    miss_idx_d   = miss_idx_q;
    abort_d      = abort_q;
    ram_read     = 1'b0;
    ram_write    = 1'b0;
    ram_addr     = '0;
    ram_data_w   = '0;
    w_fill_we    = 1'b0;
    w_fill_ok    = 1'b0;
    w_fill_abort = 1'b0;
    w_line_clr   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // A raw hit killed by a same-cycle snoop just stalls; the miss is
        // taken next cycle once the line reads as invalid.
        if (w_req && !w_raw_hit) begin
          miss_tag_d = w_cpu_tag;
          miss_idx_d = w_cpu_idx;
          cnt_d      = '0;
          abort_d    = 1'b0;
          if (w_victim_dirty) begin
            state_d = ST_WB;
          end else begin
            state_d    = ST_FILL;
            w_line_clr = 1'b1;
          end
        end
      end
      ST_WB: begin
        ram_write  = 1'b1;
        ram_addr   = {tag_q[miss_idx_q], miss_idx_q, cnt_q};
        ram_data_w = data_q[{miss_idx_q, cnt_q}];
        if (!ram_wait) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_d    = ST_FILL;
            w_line_clr = 1'b1;
          end
        end
      end
      ST_FILL: begin
        ram_read = 1'b1;
        ram_addr = {miss_tag_q, miss_idx_q, cnt_q};
        if (w_inv_miss) abort_d = 1'b1;
        if (!ram_wait) begin
          w_fill_we = 1'b1;
          cnt_d     = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            abort_d = 1'b0;
            if (abort_q || w_inv_miss) begin
              w_fill_abort = 1'b1;   // refetch: line may hold stale words
            end else begin
              w_fill_ok = 1'b1;
              state_d   = ST_IDLE;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      miss_tag_q <= '0;
      miss_idx_q <= '0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      miss_tag_q <= miss_tag_d;
      miss_idx_q <= miss_idx_d;
      abort_q    <= abort_d;
    end
  end

  // The line is marked invalid as soon as its refill starts, so a snoop on
  // the old tag can never clobber the valid bit set when the fill completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      if (w_cpu_we) dirty_q[w_cpu_idx] <= 1'b1;
      if (w_line_clr || w_fill_abort) begin
        valid_q[miss_idx_q] <= 1'b0;
        dirty_q[miss_idx_q] <= 1'b0;
      end
      if (w_fill_ok) begin
        valid_q[miss_idx_q] <= 1'b1;
        dirty_q[miss_idx_q] <= 1'b0;
      end
      if (w_inv_hit) begin
        valid_q[w_inv_idx] <= 1'b0;
        dirty_q[w_inv_idx] <= 1'b0;
      end
    end
  end

  // Tag and data arrays carry no reset
  always_ff @(posedge clk) begin
    if (w_cpu_we)  data_q[{w_cpu_idx, w_cpu_off}] <= cpu_data_w;
    if (w_fill_we) data_q[{miss_idx_q, cnt_q}]    <= ram_data_r;
    if (w_fill_ok) tag_q[miss_idx_q]              <= miss_tag_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_dm_wb_cache.sv
`default_nettype none
// ============================================================================
// Module   : tb_dm_wb_cache
// Purpose  : Self-checking bench for dm_wb_cache. RAM model returns
//            data = address; a monitor logs every RAM beat.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dm_wb_cache;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_read, cpu_write;
  logic [31:0] cpu_addr, cpu_data_w;
  logic        cpu_wait;
  logic [31:0] cpu_data_r;
  logic [31:0] ram_addr, ram_data_w;
  logic        ram_read, ram_write;
  logic        ram_wait;
  logic [31:0] ram_data_r;
  logic        inv_valid;
  logic [31:0] inv_addr;

  always #5 clk = ~clk;

  assign ram_data_r = ram_addr;

  dm_wb_cache dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cpu_read   (cpu_read),
    .cpu_write  (cpu_write),
    .cpu_addr   (cpu_addr),
    .cpu_data_w (cpu_data_w),
    .cpu_wait   (cpu_wait),
    .cpu_data_r (cpu_data_r),
    .ram_addr   (ram_addr),
    .ram_data_w (ram_data_w),
    .ram_read   (ram_read),
    .ram_write  (ram_write),
    .ram_wait   (ram_wait),
    .ram_data_r (ram_data_r),
    .inv_valid  (inv_valid),
    .inv_addr   (inv_addr)
  );

  // RAM beat monitor
  logic [31:0] rd_addr_q[$];
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];

  always @(posedge clk) begin
    if (rst_n) begin
      if (ram_read && !ram_wait) rd_addr_q.push_back(ram_addr);
      if (ram_write && !ram_wait) begin
        wr_addr_q.push_back(ram_addr);
        wr_data_q.push_back(ram_data_w);
      end
    end
  end

  int n_cmp = 0;
  int n_bad = 0;
  logic first_wait;
  int   stall_chk, unstable;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic chk_beats(input string nm, input int rb0, input int wb0,
                           input int exp_rb, input int exp_wb,
                           input logic [31:0] rbase, input logic [31:0] wbase,
                           input logic [31:0] pa, input logic [31:0] pd);
    int bad_a, bad_d, nr, nw;
    logic [31:0] ea, ed;
    bad_a = 0; bad_d = 0;
    nr = rd_addr_q.size() - rb0;
    nw = wr_addr_q.size() - wb0;
    check({nm, " rd beats"}, nr, exp_rb);
    check({nm, " wr beats"}, nw, exp_wb);
    for (int i = 0; i < nr; i++)
      if (rd_addr_q[rb0+i] !== rbase + 32'(i % 16)) bad_a++;
    for (int i = 0; i < nw; i++) begin
      ea = wbase + 32'(i % 16);
      ed = (ea == pa) ? pd : ea;
      if (wr_addr_q[wb0+i] !== ea) bad_a++;
      if (wr_data_q[wb0+i] !== ed) bad_d++;
    end
    check({nm, " beat addr errors"}, bad_a, 0);
    check({nm, " wb data errors"}, bad_d, 0);
  endtask

  // Holds one request until cpu_wait drops. inv_at = wait-cycle index at
  // which a one-cycle snoop pulse is driven (-1 = none); tog alternates
  // ram_wait 1,0,1,0 on every write-back cycle and checks stall stability.
  task automatic run_access(input string nm, input logic we, input logic [31:0] a,
                            input logic [31:0] wd, input int inv_at,
                            input logic [31:0] ia, input bit tog,
                            output logic [31:0] rd, output int waits);
    bit          ph, stalled;
    logic [31:0] pa, pd;
    ph = 1'b0; stalled = 1'b0; pa = '0; pd = '0;
    stall_chk = 0; unstable = 0;
    cpu_read = !we; cpu_write = we; cpu_addr = a; cpu_data_w = wd;
    inv_valid = (inv_at == 0); inv_addr = ia;
    waits = 0;
    #1;
    first_wait = cpu_wait;
    while (cpu_wait) begin
      if (waits >= 300) begin
        n_cmp++; n_bad++;
        $display("FAIL %s timeout: cpu_wait still 1 after %0d cycles, required 0", nm, waits);
        break;
      end
      @(negedge clk);
      waits++;
      inv_valid = (inv_at == waits); inv_addr = ia;
      if (tog) begin
        if (stalled) begin
          stall_chk++;
          if (!ram_write || ram_addr !== pa || ram_data_w !== pd) unstable++;
        end
        if (ram_write) begin ph = !ph; ram_wait = ph; end
        else ram_wait = 1'b0;
        stalled = ram_write && ph;
        pa = ram_addr; pd = ram_data_w;
      end
      #1;
    end
    rd = cpu_data_r;
    @(negedge clk);
    cpu_read = 1'b0; cpu_write = 1'b0; inv_valid = 1'b0; ram_wait = 1'b0;
  endtask

  typedef struct {
    string       nm;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    int          exp_waits;
    int          exp_rb;
    int          exp_wb;
    logic [31:0] rbase;
    logic [31:0] wbase;
    logic [31:0] pa;
    logic [31:0] pd;
  } vec_t;

  vec_t vecs[12];

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    int waits, rb0, wb0, wt;

    rst_n = 1'b0; cpu_read = 1'b0; cpu_write = 1'b0; cpu_addr = '0;
    cpu_data_w = '0; ram_wait = 1'b0; inv_valid = 1'b0; inv_addr = '0;
    repeat (3) @(negedge clk);
    check("reset ram_read",   {31'd0, ram_read},  32'd0);
    check("reset ram_write",  {31'd0, ram_write}, 32'd0);
    check("reset ram_addr",   ram_addr,   32'd0);
    check("reset ram_data_w", ram_data_w, 32'd0);
    check("reset cpu_data_r", cpu_data_r, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle cpu_wait", {31'd0, cpu_wait}, 32'd0);

    //        name   we  addr          wdata         exp_rd        waits rb  wb  rbase         wbase    patch addr    patch data
    vecs[0]  = '{"v0 rd miss",    0, 32'h0000_1230, 0, 32'h0000_1230, 17, 16, 0,  32'h0000_1230, 0,       32'hFFFF_FFFF, 0};
    vecs[1]  = '{"v1 wr hit",     1, 32'h0000_1235, 32'hDEAD_BEEF, 0, 0,  0,  0,  0,             0,       32'hFFFF_FFFF, 0};
    vecs[2]  = '{"v2 rd hit",     0, 32'h0000_1235, 0, 32'hDEAD_BEEF, 0,  0,  0,  0,             0,       32'hFFFF_FFFF, 0};
    vecs[3]  = '{"v3 wb+fill",    0, 32'h0010_1235, 0, 32'h0010_1235, 33, 16, 16, 32'h0010_1230, 32'h1230, 32'h0000_1235, 32'hDEAD_BEEF};
    vecs[4]  = '{"v4 rd hit",     0, 32'h0010_1230, 0, 32'h0010_1230, 0,  0,  0,  0,             0,       32'hFFFF_FFFF, 0};
    vecs[5]  = '{"v5 rd miss",    0, 32'h0000_2000, 0, 32'h0000_2000, 17, 16, 0,  32'h0000_2000, 0,       32'hFFFF_FFFF, 0};
    vecs[6]  = '{"v6 wr hit",     1, 32'h0000_2003, 32'h1234_5678, 0, 0,  0,  0,  0,             0,       32'hFFFF_FFFF, 0};
    vecs[7]  = '{"v7 rd hit",     0, 32'h0000_2003, 0, 32'h1234_5678, 0,  0,  0,  0,             0,       32'hFFFF_FFFF, 0};
    vecs[8]  = '{"v8 wb+fill",    0, 32'h0000_5000, 0, 32'h0000_5000, 33, 16, 16, 32'h0000_5000, 32'h2000, 32'h0000_2003, 32'h1234_5678};
    vecs[9]  = '{"v9 wr miss",    1, 32'h0000_3008, 32'hCAFE_F00D, 0, 17, 16, 0,  32'h0000_3000, 0,       32'hFFFF_FFFF, 0};
    vecs[10] = '{"v10 rd hit",    0, 32'h0000_3008, 0, 32'hCAFE_F00D, 0,  0,  0,  0,             0,       32'hFFFF_FFFF, 0};
    vecs[11] = '{"v11 rd hit",    0, 32'h0000_300F, 0, 32'h0000_300F, 0,  0,  0,  0,             0,       32'hFFFF_FFFF, 0};

    for (int i = 0; i < 12; i++) begin
      rb0 = rd_addr_q.size(); wb0 = wr_addr_q.size();
      run_access(vecs[i].nm, vecs[i].we, vecs[i].addr, vecs[i].wd, -1, 0, 1'b0, rd, waits);
      check({vecs[i].nm, " waits"}, waits, vecs[i].exp_waits);
      if (!vecs[i].we) check({vecs[i].nm, " rdata"}, rd, vecs[i].exp_rd);
      chk_beats(vecs[i].nm, rb0, wb0, vecs[i].exp_rb, vecs[i].exp_wb,
                vecs[i].rbase, vecs[i].wbase, vecs[i].pa, vecs[i].pd);
    end

    // Snoop on the same line as a write hit: stall, dirty data dropped,
    // refill, then the write lands and leaves the line dirty.
    rb0 = rd_addr_q.size(); wb0 = wr_addr_q.size();
    run_access("inv+wr", 1'b1, 32'h0000_3001, 32'h0BAD_F00D, 0, 32'h0000_3000, 1'b0, rd, waits);
    check("inv+wr first cycle cpu_wait", {31'd0, first_wait}, 32'd1);
    check("inv+wr waits", waits, 18);
    chk_beats("inv+wr", rb0, wb0, 16, 0, 32'h0000_3000, 0, 32'hFFFF_FFFF, 0);
    run_access("inv+wr rd", 1'b0, 32'h0000_3001, 0, -1, 0, 1'b0, rd, waits);
    check("inv+wr rd new word", rd, 32'h0BAD_F00D);
    run_access("inv+wr rd2", 1'b0, 32'h0000_3008, 0, -1, 0, 1'b0, rd, waits);
    check("inv+wr discarded word", rd, 32'h0000_3008);
    rb0 = rd_addr_q.size(); wb0 = wr_addr_q.size();
    run_access("dirty evict", 1'b0, 32'h0000_7000, 0, -1, 0, 1'b0, rd, waits);
    chk_beats("dirty evict", rb0, wb0, 16, 16, 32'h0000_7000, 32'h0000_3000, 32'h0000_3001, 32'h0BAD_F00D);

    // Snoop on the miss line during FILL beat 7: fill repeats
    rb0 = rd_addr_q.size(); wb0 = wr_addr_q.size();
    run_access("fill abort", 1'b0, 32'h0000_2000, 0, 8, 32'h0000_2004, 1'b0, rd, waits);
    check("fill abort waits", waits, 33);
    check("fill abort rdata", rd, 32'h0000_2000);
    chk_beats("fill abort", rb0, wb0, 32, 0, 32'h0000_2000, 0, 32'hFFFF_FFFF, 0);

    // ram_wait toggling through a write-back
    run_access("tog wr", 1'b1, 32'h0000_200A, 32'hA5A5_A5A5, -1, 0, 1'b0, rd, waits);
    rb0 = rd_addr_q.size(); wb0 = wr_addr_q.size();
    run_access("tog wb", 1'b0, 32'h0000_9000, 0, -1, 0, 1'b1, rd, waits);
    check("tog wb waits", waits, 49);
    check("tog wb stall checks", stall_chk, 16);
    check("tog wb unstable", unstable, 0);
    check("tog wb rdata", rd, 32'h0000_9000);
    chk_beats("tog wb", rb0, wb0, 16, 16, 32'h0000_9000, 32'h0000_2000, 32'h0000_200A, 32'hA5A5_A5A5);

    // Reset during FILL beat 9
    rb0 = rd_addr_q.size();
    cpu_read = 1'b1; cpu_addr = 32'h0000_4000; wt = 0;
    while (rd_addr_q.size() - rb0 < 9 && wt < 100) begin
      @(negedge clk); wt++;
    end
    check("rst mid-fill reached beat 9", rd_addr_q.size() - rb0, 9);
    rst_n = 1'b0;
    #1;
    check("rst mid-fill ram_read", {31'd0, ram_read}, 32'd0);
    check("rst mid-fill ram_addr", ram_addr, 32'd0);
    check("rst mid-fill cpu_wait", {31'd0, cpu_wait}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    rb0 = rd_addr_q.size(); wb0 = wr_addr_q.size();
    run_access("post-rst", 1'b0, 32'h0000_4000, 0, -1, 0, 1'b0, rd, waits);
    check("post-rst waits", waits, 17);
    check("post-rst rdata", rd, 32'h0000_4000);
    chk_beats("post-rst", rb0, wb0, 16, 0, 32'h0000_4000, 0, 32'hFFFF_FFFF, 0);

    // Request dropped mid-fill: fill completes, FSM returns to IDLE
    rb0 = rd_addr_q.size(); wb0 = wr_addr_q.size();
    cpu_read = 1'b1; cpu_addr = 32'h0000_B000;
    repeat (5) @(negedge clk);
    cpu_read = 1'b0;
    repeat (20) @(negedge clk);
    chk_beats("drop", rb0, wb0, 16, 0, 32'h0000_B000, 0, 32'hFFFF_FFFF, 0);
    check("drop idle ram_read", {31'd0, ram_read}, 32'd0);
    run_access("drop rd", 1'b0, 32'h0000_B000, 0, -1, 0, 1'b0, rd, waits);
    check("drop rd waits", waits, 0);
    check("drop rd rdata", rd, 32'h0000_B000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
